// File: rtl/rv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_core_pkg
// Brief    : Shared defaults, address-width helper and register-address type.
// Revision : 1.0
// ============================================================================
package rv_core_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef logic [clog2_f(NREGS_DEF)-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_mp_if
// Brief    : Read, writeback, issue and flush bundle between pipeline and RF.
// Revision : 1.0
// ============================================================================
interface regfile_scoreboard_mp_if
    import rv_core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2
);
    localparam int AW = clog2_f(NREGS);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   wb_valid;
    logic [AW-1:0]          wb_addr;
    logic [XLEN-1:0]        wb_data;
    logic                   iss_valid;
    logic [AW-1:0]          iss_addr;
    logic                   flush;
    logic [AW:0]            busy_count;

    modport master (
        output rd_addr, wb_valid, wb_addr, wb_data, iss_valid, iss_addr, flush,
        input  rd_data, rd_busy, busy_count
    );

    modport slave (
        input  rd_addr, wb_valid, wb_addr, wb_data, iss_valid, iss_addr, flush,
        output rd_data, rd_busy, busy_count
    );

endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Per-register busy bits with an incrementally kept population count.
// Revision : 1.0
// ============================================================================
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             iss_valid,
    input  wire logic [AW-1:0]    iss_addr,
    input  wire logic             wb_valid,
    input  wire logic [AW-1:0]    wb_addr,
    input  wire logic             flush,
    output logic      [NREGS-1:0] busy,
    output logic      [AW:0]      busy_count
);

    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_count;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_count_nxt;
    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;

    always_comb begin
        w_set = iss_valid && (iss_addr != '0) && !flush;
        w_clr = wb_valid && (wb_addr != '0);
        w_inc = w_set && !r_busy[iss_addr];
        // A same-address issue re-arms the bit, so the writeback does not release it.
        w_dec = w_clr && r_busy[wb_addr] && !(w_set && (iss_addr == wb_addr));

        w_busy_nxt  = r_busy;
        w_count_nxt = r_count;
        if (w_clr) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt  = '0;
            w_count_nxt = '0;
        end else if (w_inc && !w_dec) begin
            w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
        end else if (w_dec && !w_inc) begin
            w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign busy       = r_busy;
    assign busy_count = r_count;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_mp
// Brief    : Multi-port integer register file with busy scoreboard and bypass.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard_mp
    import rv_core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    regfile_scoreboard_mp_if.slave rf
);

    localparam int AW = clog2_f(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_wr;

    assign w_wr = rf.wb_valid && (rf.wb_addr != '0);

    // Entry 0 is only ever cleared, which keeps x0 reading zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[rf.wb_addr] <= rf.wb_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .iss_valid  (rf.iss_valid),
        .iss_addr   (rf.iss_addr),
        .wb_valid   (rf.wb_valid),
        .wb_addr    (rf.wb_addr),
        .flush      (rf.flush),
        .busy       (w_busy),
        .busy_count (rf.busy_count)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;

        assign w_ra = rf.rd_addr[k*AW +: AW];

        if (BYPASS != 0) begin : g_byp
            assign w_hit = w_wr && (w_ra == rf.wb_addr);
        end else begin : g_nobyp
            assign w_hit = 1'b0;
        end

        assign rf.rd_data[k*XLEN +: XLEN] = w_hit ? rf.wb_data : r_regs[w_ra];
        assign rf.rd_busy[k]              = w_hit ? 1'b0 : w_busy[w_ra];
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard_mp
// Brief    : Vector-table bench driving a bypassing and a non-bypassing RF.
// Revision : 1.0
// ============================================================================
module tb_regfile_scoreboard_mp;
    import rv_core_pkg::*;

    typedef struct {
        reg_addr_t   ra0;
        reg_addr_t   ra1;
        logic        wbv;
        reg_addr_t   wba;
        logic [31:0] wbd;
        logic        issv;
        reg_addr_t   issa;
        logic        fl;
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
        logic [5:0]  cnt;
        logic [31:0] nd0;
        logic        nb0;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    vec_t exp_q[$];
    vec_t tbl[12];

    regfile_scoreboard_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) if1 ();
    regfile_scoreboard_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) if0 ();

    regfile_scoreboard_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dut_byp (
        .clk   (clk),
        .reset (reset),
        .rf    (if1)
    );

    regfile_scoreboard_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dut_nobyp (
        .clk   (clk),
        .reset (reset),
        .rf    (if0)
    );

    assign if0.rd_addr   = if1.rd_addr;
    assign if0.wb_valid  = if1.wb_valid;
    assign if0.wb_addr   = if1.wb_addr;
    assign if0.wb_data   = if1.wb_data;
    assign if0.iss_valid = if1.iss_valid;
    assign if0.iss_addr  = if1.iss_addr;
    assign if0.flush     = if1.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input int ra0, input int ra1, input logic wbv, input int wba, input logic [31:0] wbd,
        input logic issv, input int issa, input logic fl,
        input logic [31:0] d0, input logic b0, input logic [31:0] d1, input logic b1,
        input int cnt, input logic [31:0] nd0, input logic nb0);
        vec_t v;
        v.ra0 = reg_addr_t'(ra0);  v.ra1 = reg_addr_t'(ra1);
        v.wbv = wbv;  v.wba = reg_addr_t'(wba);  v.wbd = wbd;
        v.issv = issv;  v.issa = reg_addr_t'(issa);  v.fl = fl;
        v.d0 = d0;  v.b0 = b0;  v.d1 = d1;  v.b1 = b1;
        v.cnt = 6'(cnt);  v.nd0 = nd0;  v.nb0 = nb0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        if1.wb_valid  = 1'b0;
        if1.wb_addr   = '0;
        if1.wb_data   = '0;
        if1.iss_valid = 1'b0;
        if1.iss_addr  = '0;
        if1.flush     = 1'b0;
    endtask

    // Drive on the falling edge, sample 1ns later, let the rising edge commit.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        if1.rd_addr   = {v.ra1, v.ra0};
        if1.wb_valid  = v.wbv;
        if1.wb_addr   = v.wba;
        if1.wb_data   = v.wbd;
        if1.iss_valid = v.issv;
        if1.iss_addr  = v.issa;
        if1.flush     = v.fl;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        check("byp_d0",  if1.rd_data[31:0],  e.d0);
        check("byp_b0",  32'(if1.rd_busy[0]), 32'(e.b0));
        check("byp_d1",  if1.rd_data[63:32], e.d1);
        check("byp_b1",  32'(if1.rd_busy[1]), 32'(e.b1));
        check("byp_cnt", 32'(if1.busy_count), 32'(e.cnt));
        check("nob_d0",  if0.rd_data[31:0],  e.nd0);
        check("nob_b0",  32'(if0.rd_busy[0]), 32'(e.nb0));
        check("nob_cnt", 32'(if0.busy_count), 32'(e.cnt));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        if1.rd_addr = '0;
        idle_inputs();

        //          ra0 ra1 wbv wba wbd          iv ia fl d0            b0 d1            b1 cnt nd0           nb0
        tbl[0]  = mk(5, 0,  0,  0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
        tbl[1]  = mk(5, 7,  0,  0, 32'h0,        1, 5, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
        tbl[2]  = mk(5, 5,  0,  0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h0,        1);
        tbl[3]  = mk(5, 5,  1,  5, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1, 32'h0,        1);
        tbl[4]  = mk(5, 0,  0,  0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0, 32'h0,        0, 0, 32'hDEADBEEF, 0);
        tbl[5]  = mk(7, 5,  0,  0, 32'h0,        1, 7, 0, 32'h0,        0, 32'hDEADBEEF, 0, 0, 32'h0,        0);
        tbl[6]  = mk(7, 7,  1,  7, 32'h12,       1, 7, 0, 32'h12,       0, 32'h12,       0, 1, 32'h0,        1);
        tbl[7]  = mk(7, 0,  0,  0, 32'h0,        0, 0, 0, 32'h12,       1, 32'h0,        0, 1, 32'h12,       1);
        tbl[8]  = mk(0, 0,  1,  0, 32'hFFFF,     1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        0);
        tbl[9]  = mk(0, 7,  0,  0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h12,       1, 1, 32'h0,        0);
        tbl[10] = mk(3, 7,  1,  7, 32'h34,       0, 0, 0, 32'h0,        0, 32'h34,       0, 1, 32'h0,        0);
        tbl[11] = mk(7, 7,  0,  0, 32'h0,        0, 0, 0, 32'h34,       0, 32'h34,       0, 0, 32'h34,       0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Post-reset sweep of every address on both ports.
        for (int a = 0; a < 32; a++) begin
            apply(mk(a, 31 - a, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));
        end

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
        end

        // Four issues, then flush racing an issue and a writeback; then WAW.
        apply(mk(1, 2, 0, 0, 32'h0,  1, 1, 0, 32'h0, 0, 32'h0,  0, 0, 32'h0, 0));
        apply(mk(1, 2, 0, 0, 32'h0,  1, 2, 0, 32'h0, 1, 32'h0,  0, 1, 32'h0, 1));
        apply(mk(2, 3, 0, 0, 32'h0,  1, 3, 0, 32'h0, 1, 32'h0,  0, 2, 32'h0, 1));
        apply(mk(3, 4, 0, 0, 32'h0,  1, 4, 0, 32'h0, 1, 32'h0,  0, 3, 32'h0, 1));
        apply(mk(4, 2, 1, 2, 32'h55, 1, 9, 1, 32'h0, 1, 32'h55, 0, 4, 32'h0, 1));
        apply(mk(9, 2, 0, 0, 32'h0,  1, 6, 0, 32'h0, 0, 32'h55, 0, 0, 32'h0, 0));
        apply(mk(6, 6, 0, 0, 32'h0,  1, 6, 0, 32'h0, 1, 32'h0,  1, 1, 32'h0, 1));
        apply(mk(6, 1, 0, 0, 32'h0,  0, 0, 0, 32'h0, 1, 32'h0,  0, 1, 32'h0, 1));

        // Build count=3 with x3=0xA5, then pulse reset between edges.
        apply(mk(3, 0, 1, 3, 32'hA5, 0, 0, 0, 32'hA5, 0, 32'h0, 0, 1, 32'h0,  0));
        apply(mk(3, 0, 0, 0, 32'h0,  1, 1, 0, 32'hA5, 0, 32'h0, 0, 1, 32'hA5, 0));
        apply(mk(3, 6, 0, 0, 32'h0,  1, 3, 0, 32'hA5, 0, 32'h0, 1, 2, 32'hA5, 0));
        apply(mk(3, 1, 0, 0, 32'h0,  0, 0, 0, 32'hA5, 1, 32'h0, 1, 3, 32'hA5, 1));

        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        check("rst_byp_cnt", 32'(if1.busy_count), 32'h0);
        check("rst_byp_d0",  if1.rd_data[31:0], 32'h0);
        check("rst_byp_b0",  32'(if1.rd_busy[0]), 32'h0);
        check("rst_byp_b1",  32'(if1.rd_busy[1]), 32'h0);
        check("rst_nob_cnt", 32'(if0.busy_count), 32'h0);
        check("rst_nob_d0",  if0.rd_data[31:0], 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        apply(mk(3, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));
        apply(mk(3, 0, 0, 0, 32'h0, 1, 3, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));
        apply(mk(3, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 1, 32'h0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard_mp.md
Name: regfile_scoreboard_mp

Overview:
- Parametrised integer register file for the pipelined successor of the single-cycle RV32I core.
- Provides NUM_RD combinational read ports, one writeback port and an optional write-to-read bypass.
- Includes a per-register busy scoreboard: issue sets a busy bit for the destination register, and writeback clears it.
- Decode uses rd_busy to stall on RAW hazards; the pipeline uses flush to drop in-flight producers on redirect.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, ≥2; AW = log2(NREGS).
- NUM_RD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = writeback data and busy-clear are forwarded combinationally to same-cycle reads; 0 = no forwarding.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, reset, asynchronous, active-high.
- rd_addr, input, NUM_RD*AW, packed read addresses; port k uses bits [k*AW +: AW].
- rd_data, output, NUM_RD*XLEN, packed read data, combinational.
- rd_busy, output, NUM_RD, port k's register has an outstanding producer; combinational.
- wb_valid, input, 1, writeback strobe.
- wb_addr, input, AW, writeback destination.
- wb_data, input, XLEN, writeback data.
- iss_valid, input, 1, an instruction writing iss_addr has issued.
- iss_addr, input, AW, destination of the issued instruction.
- flush, input, 1, synchronous clear of all busy bits.
- busy_count, output, AW+1, registered population count of busy bits.

Behaviour:
- Reset (async):
  - all registers = 0;
  - busy[] = 0;
  - busy_count = 0;
  - rd_data and rd_busy therefore read 0 for every address.
- Register 0:
  - always reads 0 and is never busy;
  - writeback and issue to address 0 are ignored entirely, with no count change.
- Writeback:
  - when wb_valid && wb_addr≠0, regs[wb_addr] ← wb_data at the edge;
  - busy[wb_addr] is cleared at the same edge;
  - the data write happens whether or not the register was busy.
- Issue:
  - when iss_valid && iss_addr≠0 && !flush, busy[iss_addr] ← 1 at the edge;
  - issuing to an already-busy register (WAW) leaves the bit set.
- Issue and writeback to the same address in the same cycle:
  - data is written;
  - busy ends set, because the new producer wins.
- Flush:
  - all busy bits ← 0 at the edge and busy_count ← 0;
  - iss_valid in the flush cycle is dropped;
  - wb_valid in the flush cycle still writes data;
  - register contents are unaffected by flush.
- busy_count:
  - equals popcount(busy) after every edge;
  - maintained incrementally as +1 for a 0→1 transition and −1 for a 1→0 transition;
  - net change per cycle is in {−1, 0, +1};
  - never exceeds NREGS−1.
- Read port k, BYPASS=1:
  - if wb_valid && wb_addr≠0 && rd_addr_k==wb_addr, then rd_data_k = wb_data and rd_busy_k = 0;
  - otherwise rd_data_k = regs[rd_addr_k] and rd_busy_k = busy[rd_addr_k].
- Read port k, BYPASS=0: reads always return the stored state, so data written this cycle is visible from the next cycle.
- Read ports are independent; any number may alias the same address.
- Reset asserted mid-operation: all state is cleared immediately; the first edge after deassertion behaves as after power-up.

Decomposition:
- Shared package rv_core_pkg holds:
  - XLEN_DEF = 32;
  - NREGS_DEF = 32;
  - a clog2-style function for AW;
  - typedef of the register-address type.
- The natural sub-module is rf_scoreboard: busy vector plus busy_count, with inputs iss/wb/flush and outputs busy[] and busy_count.
- The top level holds the storage array, the read muxes and the bypass logic.

Test Plan:
- Reset, then read all 32 addresses on both ports → rd_data=0, rd_busy=0, busy_count=0.
- Issue x5, next cycle read x5 → rd_busy=1, busy_count=1. Then wb x5=0xDEADBEEF with rd_addr0=5 in the same cycle, BYPASS=1 → rd_data0=0xDEADBEEF, rd_busy0=0; busy_count=0 after the edge.
- Same wb with BYPASS=0 → same-cycle read returns the old value 0 with rd_busy0=1; the next cycle returns 0xDEADBEEF and 0.
- Same-cycle iss x7 + wb x7=0x12 → x7 reads 0x12, busy stays 1, busy_count unchanged. Separately, iss x0 + wb x0=0xFFFF → x0 reads 0, not busy, count 0.
- Issue x1..x4 on consecutive cycles (count=4), then flush with concurrent iss x9 and wb x2=0x55 → busy_count=0, x9 not busy, x2=0x55.
- Assert reset asynchronously mid-sequence with count=3 and x3=0xA5 → outputs go to 0 before the next edge; x3 reads 0 after reset.
